// File: rtl/quad_step_decoder_if.sv
// Pin bundle for the quadrature step decoder: control/phase inputs, count and status outputs.
interface quad_step_decoder_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronizes and debounces A/B, decodes Gray steps into a wrapping
// position count with direction, step pulse and a sticky illegal-transition flag.
module quad_step_decoder #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEB_LEN = 3
) (
  input logic                clk,
  input logic                rst_n,
  quad_step_decoder_if.slave bus
);

  localparam logic [3:0] DebLen = 4'(DEB_LEN);

  logic [1:0]       ab_s1_q, ab_s2_q;   // {A,B}
  logic [1:0]       ctl_s1_q, ctl_s2_q; // {err_clr, clr}
  logic [1:0]       fill_q;
  logic [1:0]       cand_q;
  logic [3:0]       stab_q, stab_d;
  logic [1:0]       filt_q;
  logic             primed_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             step_q, step_d;

  logic             sync_valid;
  logic             accept;
  logic             is_up, is_dn, is_diag;
  logic             step_up, step_dn, illegal;
  logic             clr_s, err_clr_s;
  logic             unused_in;

  assign unused_in  = ^{bus.ena, bus.uio_in, bus.ui_in[7:4]};
  assign clr_s      = ctl_s2_q[0];
  assign err_clr_s  = ctl_s2_q[1];
  // The filter stays idle until the synchronizer holds real samples, so the reset-cleared
  // pipeline value can never be mistaken for the priming state.
  assign sync_valid = fill_q[1];

  always_comb begin
    stab_d = stab_q;
    if (sync_valid) begin
      if (ab_s2_q != cand_q) begin
        stab_d = 4'd1;
      end else if (stab_q < DebLen) begin
        stab_d = stab_q + 4'd1;
      end
    end
  end

  assign accept = sync_valid && (stab_d == DebLen);

  always_comb begin
    is_up   = 1'b0;
    is_dn   = 1'b0;
    is_diag = 1'b0;
    case ({filt_q, ab_s2_q})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: is_up   = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: is_dn   = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: is_diag = 1'b1;
      default: ;
    endcase
  end

  assign step_up = accept && primed_q && is_up;
  assign step_dn = accept && primed_q && is_dn;
  assign illegal = accept && primed_q && is_diag;

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    err_d   = err_q;
    step_d  = 1'b0;
    if (step_up) begin
      count_d = count_q + 1'b1;
      dir_d   = 1'b1;
      step_d  = 1'b1;
    end else if (step_dn) begin
      count_d = count_q - 1'b1;
      dir_d   = 1'b0;
      step_d  = 1'b1;
    end
    // Clear discards the count change only; dir and step still reflect the step.
    if (clr_s) begin
      count_d = '0;
    end
    if (err_clr_s) begin
      err_d = 1'b0;
    end
    if (illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_s1_q  <= 2'b00;
      ab_s2_q  <= 2'b00;
      ctl_s1_q <= 2'b00;
      ctl_s2_q <= 2'b00;
      fill_q   <= 2'b00;
      cand_q   <= 2'b00;
      stab_q   <= 4'd0;
      filt_q   <= 2'b00;
      primed_q <= 1'b0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      ab_s1_q  <= {bus.ui_in[0], bus.ui_in[1]};
      ab_s2_q  <= ab_s1_q;
      ctl_s1_q <= {bus.ui_in[3], bus.ui_in[2]};
      ctl_s2_q <= ctl_s1_q;
      fill_q   <= {fill_q[0], 1'b1};
      stab_q   <= stab_d;
      if (sync_valid) begin
        cand_q <= ab_s2_q;
      end
      if (accept) begin
        filt_q   <= ab_s2_q;
        primed_q <= 1'b1;
      end
      count_q  <= count_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      step_q   <= step_d;
    end
  end

  assign bus.uo_out  = 8'(count_q);
  assign bus.uio_out = {5'b00000, step_q, err_q, dir_q};
  assign bus.uio_oe  = 8'b00000111;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: directed scenarios plus randomized step/glitch
// sequences checked against a Gray-position arithmetic model.
module tb_quad_step_decoder;

  localparam int CNT_W   = 8;
  localparam int DEB_LEN = 3;
  localparam int LAT     = 2 + DEB_LEN;
  localparam int MOD     = 1 << CNT_W;

  logic clk;
  logic rst_n;
  quad_step_decoder_if bus_if ();

  quad_step_decoder #(
    .CNT_W  (CNT_W),
    .DEB_LEN(DEB_LEN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int pulse_total;

  // Model: filtered {A,B} state, position, direction, sticky error.
  logic [1:0] m_ab;
  int         m_count;
  bit         m_dir;
  bit         m_err;
  logic [1:0] gseq [4];

  function automatic int gidx(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (gseq[i] == ab) return i;
    return 0;
  endfunction

  function automatic logic [1:0] gstep(input logic [1:0] ab, input int delta);
    return gseq[(gidx(ab) + delta + 4) % 4];
  endfunction

  task automatic set_ab(input logic [1:0] ab);
    bus_if.ui_in[0] = ab[1];
    bus_if.ui_in[1] = ab[0];
  endtask

  // Drive a new {A,B}, hold it, and check pulse timing plus final count/dir/err.
  task automatic apply(input logic [1:0] ab, input int hold, input bit clr_hold);
    int d, npulse, at, exp_np, exp_at;
    d = (gidx(ab) - gidx(m_ab) + 4) % 4;
    if (d == 1) begin
      m_count = (m_count + 1) % MOD;
      m_dir   = 1'b1;
    end else if (d == 3) begin
      m_count = (m_count + MOD - 1) % MOD;
      m_dir   = 1'b0;
    end else if (d == 2) begin
      m_err = 1'b1;
    end
    if (clr_hold) m_count = 0;
    m_ab = ab;
    set_ab(ab);
    if (clr_hold) bus_if.ui_in[2] = 1'b1;
    npulse = 0;
    at     = -1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (bus_if.uio_out[2] === 1'b1) begin
        npulse++;
        if (at < 0) at = k;
      end
    end
    if (clr_hold) bus_if.ui_in[2] = 1'b0;
    pulse_total += npulse;
    exp_np = (d == 1 || d == 3) ? 1 : 0;
    exp_at = (exp_np == 1) ? LAT : -1;
    checks++;
    if (npulse !== exp_np || at !== exp_at) begin
      failures++;
      $display("FAIL step_pulse: got %0d pulses at cycle %0d, expected %0d at cycle %0d",
               npulse, at, exp_np, exp_at);
    end
    checks++;
    if (bus_if.uo_out !== 8'(m_count)) begin
      failures++;
      $display("FAIL count: got %0h expected %0h", bus_if.uo_out, 8'(m_count));
    end
    checks++;
    if (bus_if.uio_out[0] !== m_dir) begin
      failures++;
      $display("FAIL dir: got %0b expected %0b", bus_if.uio_out[0], m_dir);
    end
    checks++;
    if (bus_if.uio_out[1] !== m_err) begin
      failures++;
      $display("FAIL err: got %0b expected %0b", bus_if.uio_out[1], m_err);
    end
  endtask

  // Short pulse on one phase; must leave everything untouched.
  task automatic glitch(input bit on_a, input int len);
    int npulse;
    set_ab(m_ab ^ (on_a ? 2'b10 : 2'b01));
    repeat (len) @(negedge clk);
    set_ab(m_ab);
    npulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.uio_out[2] === 1'b1) npulse++;
    end
    checks++;
    if (npulse !== 0 || bus_if.uo_out !== 8'(m_count) || bus_if.uio_out[1] !== m_err) begin
      failures++;
      $display("FAIL glitch: got pulses=%0d count=%0h err=%0b expected 0/%0h/%0b",
               npulse, bus_if.uo_out, bus_if.uio_out[1], 8'(m_count), m_err);
    end
  endtask

  task automatic pulse_clr();
    bus_if.ui_in[2] = 1'b1;
    repeat (3) @(negedge clk);
    bus_if.ui_in[2] = 1'b0;
    repeat (4) @(negedge clk);
    m_count = 0;
    checks++;
    if (bus_if.uo_out !== 8'h00) begin
      failures++;
      $display("FAIL clr: got %0h expected 00", bus_if.uo_out);
    end
  endtask

  task automatic pulse_err_clr();
    bus_if.ui_in[3] = 1'b1;
    @(negedge clk);
    bus_if.ui_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    m_err = 1'b0;
    checks++;
    if (bus_if.uio_out[1] !== 1'b0) begin
      failures++;
      $display("FAIL err_clr: got %0b expected 0", bus_if.uio_out[1]);
    end
  endtask

  // After reset release the first accepted state must prime silently.
  task automatic check_priming(input string name);
    int npulse;
    npulse = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.uio_out[2] === 1'b1) npulse++;
    end
    checks++;
    if (npulse !== 0 || bus_if.uo_out !== 8'h00 || bus_if.uio_out !== 8'h00) begin
      failures++;
      $display("FAIL %s: got pulses=%0d uo_out=%0h uio_out=%0h expected 0/00/00",
               name, npulse, bus_if.uo_out, bus_if.uio_out);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus_if.ena    = 1'b1;
    bus_if.uio_in = 8'h00;
    bus_if.ui_in  = 8'h00;
    set_ab(2'b11);
    #12;
    checks++;
    if (bus_if.uo_out !== 8'h00 || bus_if.uio_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_out: got uo_out=%0h uio_out=%0h expected 00/00",
               bus_if.uo_out, bus_if.uio_out);
    end
    checks++;
    if (bus_if.uio_oe !== 8'h07) begin
      failures++;
      $display("FAIL uio_oe: got %0h expected 07", bus_if.uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ab = 2'b11; m_count = 0; m_dir = 1'b0; m_err = 1'b0;
    check_priming("prime_after_reset");
  endtask

  task automatic test_up4();
    apply(2'b10, 10, 1'b0);
    apply(2'b00, 10, 1'b0);
    apply(2'b01, 10, 1'b0);
    apply(2'b11, 10, 1'b0);
    checks++;
    if (bus_if.uo_out !== 8'h04 || bus_if.uio_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL up4: got count=%0h dir=%0b expected 04/1", bus_if.uo_out, bus_if.uio_out[0]);
    end
  endtask

  task automatic test_wrap();
    apply(2'b10, 10, 1'b0);
    apply(2'b00, 10, 1'b0);
    pulse_clr();
    apply(2'b10, 10, 1'b0);
    checks++;
    if (bus_if.uo_out !== 8'hFF || bus_if.uio_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_down: got count=%0h dir=%0b expected ff/0",
               bus_if.uo_out, bus_if.uio_out[0]);
    end
    apply(2'b00, 10, 1'b0);
    checks++;
    if (bus_if.uo_out !== 8'h00) begin
      failures++;
      $display("FAIL wrap_up: got count=%0h expected 00", bus_if.uo_out);
    end
  endtask

  task automatic test_glitch_illegal();
    glitch(1'b1, 2);
    glitch(1'b0, 1);
    apply(2'b11, 10, 1'b0);
    checks++;
    if (bus_if.uio_out[1] !== 1'b1 || bus_if.uo_out !== 8'h00) begin
      failures++;
      $display("FAIL illegal: got err=%0b count=%0h expected 1/00",
               bus_if.uio_out[1], bus_if.uo_out);
    end
    pulse_err_clr();
  endtask

  task automatic test_clr_step();
    apply(2'b01, 10, 1'b0);
    apply(2'b11, 10, 1'b1);
    checks++;
    if (bus_if.uo_out !== 8'h00 || bus_if.uio_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL clr_step: got count=%0h dir=%0b expected 00/1",
               bus_if.uo_out, bus_if.uio_out[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) glitch($urandom_range(0, 1) == 1, $urandom_range(1, 2));
      // Mostly legal steps; roughly one in six is a diagonal jump.
      if ($urandom_range(0, 5) == 0) begin
        apply(gstep(m_ab, 2), $urandom_range(6, 10), 1'b0);
      end else begin
        apply(gstep(m_ab, ($urandom_range(0, 1) == 1) ? 1 : -1), $urandom_range(6, 10), 1'b0);
      end
      if (m_err && $urandom_range(0, 2) == 0) pulse_err_clr();
    end
  endtask

  task automatic test_spin();
    pulse_err_clr();
    pulse_clr();
    pulse_total = 0;
    for (int i = 0; i < 300; i++) apply(gstep(m_ab, 1), 6, 1'b0);
    checks++;
    if (bus_if.uo_out !== 8'h2C || pulse_total !== 300 || bus_if.uio_out[1] !== 1'b0) begin
      failures++;
      $display("FAIL spin300: got count=%0h pulses=%0d err=%0b expected 2c/300/0",
               bus_if.uo_out, pulse_total, bus_if.uio_out[1]);
    end
  endtask

  task automatic test_reset_mid();
    pulse_clr();
    for (int i = 0; i < 'h37; i++) apply(gstep(m_ab, 1), 6, 1'b0);
    apply(gstep(m_ab, 2), 8, 1'b0);
    checks++;
    if (bus_if.uo_out !== 8'h37 || bus_if.uio_out[1] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got count=%0h err=%0b expected 37/1",
               bus_if.uo_out, bus_if.uio_out[1]);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.uo_out !== 8'h00 || bus_if.uio_out !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: got uo_out=%0h uio_out=%0h expected 00/00",
               bus_if.uo_out, bus_if.uio_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_count = 0; m_dir = 1'b0; m_err = 1'b0;
    check_priming("reprime");
    apply(gstep(m_ab, 1), 10, 1'b0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    pulse_total = 0;
    gseq[0] = 2'b00;
    gseq[1] = 2'b01;
    gseq[2] = 2'b11;
    gseq[3] = 2'b10;
    test_reset();
    test_up4();
    test_wrap();
    test_glitch_illegal();
    test_clr_step();
    test_random();
    test_spin();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
